// File: rtl/seq_addsub.sv
// Multi-cycle adder/subtractor: processes CHUNK bits per clock, LSB chunk first,
// and writes the full result plus carry/overflow/zero flags once at the end.
module seq_addsub #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ov,
    output logic             zero
);
    localparam int NCH = WIDTH / CHUNK;
    localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_reg;
    logic             sub_reg;
    logic             carry_reg;
    logic [CW-1:0]    cnt_reg;
    logic [WIDTH-1:0] x_reg;
    logic [WIDTH-1:0] y_reg;

    logic [CHUNK:0]   c;
    logic [CHUNK-1:0] sum_chunk;
    logic [WIDTH-1:0] x_next;
    logic [WIDTH-1:0] y_next;
    logic             last_chunk;

    // Ripple chain across one chunk; c[CHUNK-1] is the carry into the chunk MSB.
    assign c[0] = carry_reg;
    generate
        for (genvar gi = 0; gi < CHUNK; gi++) begin : g_ripple
            logic yb;
            assign yb            = y_reg[gi] ^ sub_reg;
            assign sum_chunk[gi] = x_reg[gi] ^ yb ^ c[gi];
            assign c[gi+1]       = (x_reg[gi] & yb) | (x_reg[gi] & c[gi]) | (yb & c[gi]);
        end
    endgenerate

    // x_reg doubles as the result register: chunk sums shift in from the top
    // while consumed operand chunks shift out of the bottom.
    generate
        if (NCH == 1) begin : g_single
            assign x_next = sum_chunk;
            assign y_next = y_reg;
        end else begin : g_multi
            assign x_next = {sum_chunk, x_reg[WIDTH-1:CHUNK]};
            assign y_next = {{CHUNK{1'b0}}, y_reg[WIDTH-1:CHUNK]};
        end
    endgenerate

    assign last_chunk = (cnt_reg == CW'(NCH - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            s         <= '0;
            cout      <= 1'b0;
            ov        <= 1'b0;
            zero      <= 1'b0;
            cnt_reg   <= '0;
            carry_reg <= 1'b0;
            sub_reg   <= 1'b0;
            x_reg     <= '0;
            y_reg     <= '0;
        end else begin
            done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        sub_reg   <= op[0];
                        x_reg     <= op[1] ? s : a;
                        y_reg     <= op[1] ? a : b;
                        cnt_reg   <= '0;
                        carry_reg <= op[0];
                        busy      <= 1'b1;
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    x_reg     <= x_next;
                    y_reg     <= y_next;
                    carry_reg <= c[CHUNK];
                    cnt_reg   <= cnt_reg + 1'b1;
                    if (last_chunk) begin
                        s         <= x_next;
                        cout      <= c[CHUNK];
                        ov        <= c[CHUNK] ^ c[CHUNK-1];
                        zero      <= (x_next == '0);
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_addsub.sv
// Bench for seq_addsub: four instances (CHUNK = 1, 4, 8, 16) driven one at a
// time with directed vectors and multi-cycle corner-case sequences.
module tb_seq_addsub;
    localparam int ND = 4;

    typedef struct {
        logic [1:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] s;
        logic        cout;
        logic        ov;
        logic        zero;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_w [ND];
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy_w [ND];
    logic        done_w [ND];
    logic [15:0] s_w    [ND];
    logic        cout_w [ND];
    logic        ov_w   [ND];
    logic        zero_w [ND];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    generate
        for (genvar gi = 0; gi < ND; gi++) begin : g_dut
            seq_addsub #(
                .WIDTH(16),
                .CHUNK((gi == 0) ? 1 : (gi == 1) ? 4 : (gi == 2) ? 8 : 16)
            ) u_dut (
                .clk   (clk),
                .reset (reset),
                .start (start_w[gi]),
                .op    (op),
                .a     (a),
                .b     (b),
                .busy  (busy_w[gi]),
                .done  (done_w[gi]),
                .s     (s_w[gi]),
                .cout  (cout_w[gi]),
                .ov    (ov_w[gi]),
                .zero  (zero_w[gi])
            );
        end
    endgenerate

    function automatic int chunk_of(int d);
        case (d)
            0:       return 1;
            1:       return 4;
            2:       return 8;
            default: return 16;
        endcase
    endfunction

    function automatic int nch_of(int d);
        return 16 / chunk_of(d);
    endfunction

    task automatic chk(string name, int d, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s chunk=%0d actual=0x%0h required=0x%0h", name, chunk_of(d), act, exp);
        end
    endtask

    // One-cycle start pulse, then wait (bounded) for done; leaves the bench at
    // the negedge of the done cycle so the caller can inspect results.
    task automatic do_op(int d, logic [1:0] o, logic [15:0] av, logic [15:0] bv);
        int lat;
        @(negedge clk);
        op = o; a = av; b = bv; start_w[d] = 1'b1;
        @(negedge clk);
        start_w[d] = 1'b0;
        chk("busy_after_start", d, {31'd0, busy_w[d]}, 32'd1);
        lat = 0;
        while (!done_w[d] && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", d, lat, nch_of(d));
        $display("chunk=%0d op=%0d a=%04h b=%04h -> s=%04h cout=%0b ov=%0b zero=%0b lat=%0d",
                 chunk_of(d), o, av, bv, s_w[d], cout_w[d], ov_w[d], zero_w[d], lat);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    vec_t tbl [6];

    initial begin
        int lat;
        int pulses;

        tbl[0] = '{op: 2'b00, a: 16'h7FFF, b: 16'h0001, s: 16'h8000, cout: 1'b0, ov: 1'b1, zero: 1'b0};
        tbl[1] = '{op: 2'b00, a: 16'hFFFF, b: 16'h0001, s: 16'h0000, cout: 1'b1, ov: 1'b0, zero: 1'b1};
        tbl[2] = '{op: 2'b01, a: 16'h0005, b: 16'h0005, s: 16'h0000, cout: 1'b1, ov: 1'b0, zero: 1'b1};
        tbl[3] = '{op: 2'b01, a: 16'h0003, b: 16'h0005, s: 16'hFFFE, cout: 1'b0, ov: 1'b0, zero: 1'b0};
        tbl[4] = '{op: 2'b01, a: 16'h8000, b: 16'h0001, s: 16'h7FFF, cout: 1'b1, ov: 1'b1, zero: 1'b0};
        tbl[5] = '{op: 2'b00, a: 16'h1234, b: 16'h4321, s: 16'h5555, cout: 1'b0, ov: 1'b0, zero: 1'b0};

        reset = 1'b1;
        op = 2'b00; a = '0; b = '0;
        for (int d = 0; d < ND; d++) start_w[d] = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        for (int d = 0; d < ND; d++)
            chk("reset_state", d,
                {11'd0, busy_w[d], done_w[d], s_w[d], cout_w[d], ov_w[d], zero_w[d]}, 32'd0);

        // Directed ADD/SUB vectors on every chunk size.
        for (int d = 0; d < ND; d++) begin
            for (int i = 0; i < 6; i++) begin
                do_op(d, tbl[i].op, tbl[i].a, tbl[i].b);
                chk("s", d, {16'd0, s_w[d]}, {16'd0, tbl[i].s});
                chk("flags", d, {29'd0, cout_w[d], ov_w[d], zero_w[d]},
                    {29'd0, tbl[i].cout, tbl[i].ov, tbl[i].zero});
            end
        end

        // Back-to-back accumulation with start held high through done cycles.
        for (int d = 0; d < ND; d++) begin
            do_reset();
            @(negedge clk);
            op = 2'b10; a = 16'h0010; b = 16'hAAAA; start_w[d] = 1'b1;
            for (int i = 1; i <= 3; i++) begin
                lat = 0;
                do begin
                    @(negedge clk);
                    lat++;
                end while (!done_w[d] && lat < 64);
                if (i == 3) start_w[d] = 1'b0;
                chk("acc_done_seen", d, {31'd0, done_w[d]}, 32'd1);
                chk("acc_s", d, {16'd0, s_w[d]}, 32'h10 * i);
                $display("chunk=%0d acc_add #%0d -> s=%04h", chunk_of(d), i, s_w[d]);
            end
            do_op(d, 2'b11, 16'h0030, 16'h5555);
            chk("acc_sub_s", d, {16'd0, s_w[d]}, 32'd0);
            chk("acc_sub_zero", d, {31'd0, zero_w[d]}, 32'd1);
        end

        // start during busy must be ignored; result then holds.
        for (int d = 0; d < ND; d++) begin
            @(negedge clk);
            op = 2'b00; a = 16'h1234; b = 16'h0001; start_w[d] = 1'b1;
            @(negedge clk);
            a = 16'hFFFF; b = 16'hFFFF;
            pulses = 0;
            for (int n = 0; n < nch_of(d) + 6; n++) begin
                start_w[d] = busy_w[d];
                if (done_w[d]) pulses++;
                @(negedge clk);
            end
            start_w[d] = 1'b0;
            chk("ignore_pulses", d, pulses, 1);
            chk("ignore_s_hold", d, {16'd0, s_w[d]}, 32'h1235);
            $display("chunk=%0d start-during-busy -> s=%04h pulses=%0d", chunk_of(d), s_w[d], pulses);
        end

        // Reset in the second RUN cycle aborts without a result write.
        for (int d = 0; d < ND; d++) begin
            if (nch_of(d) >= 2) begin
                @(negedge clk);
                op = 2'b00; a = 16'h0F0F; b = 16'h0101; start_w[d] = 1'b1;
                @(negedge clk);
                start_w[d] = 1'b0;
                @(negedge clk);
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                chk("abort_state", d,
                    {11'd0, busy_w[d], done_w[d], s_w[d], cout_w[d], ov_w[d], zero_w[d]}, 32'd0);
                pulses = 0;
                for (int n = 0; n < nch_of(d) + 3; n++) begin
                    @(negedge clk);
                    if (done_w[d]) pulses++;
                end
                chk("abort_no_done", d, pulses, 0);
                do_op(d, 2'b00, 16'h0002, 16'h0003);
                chk("after_abort_s", d, {16'd0, s_w[d]}, 32'd5);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
